// File: rtl/rv64_pkg.sv
// Shared widths and ALU opcode encodings for the RV64I datapath slice.
package rv64_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        ALU_ADD0 = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SLTU = 2'b10,
        ALU_SUB  = 2'b11
    } aluop_t;

endpackage

// File: rtl/rv64_regfile.sv
// 32x64 integer register file: two combinational read ports, one write port,
// synchronous clear, x0 hardwired to zero.
module rv64_regfile
    import rv64_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_AW-1:0]   raddr1,
    output logic [XLEN-1:0]     rdata1,
    input  logic [REG_AW-1:0]   raddr2,
    output logic [XLEN-1:0]     rdata2,
    input  logic                we,
    input  logic [REG_AW-1:0]   waddr,
    input  logic [XLEN-1:0]     wdata
);

    logic [XLEN-1:0] regs [NREGS];

    // Reset wins over write; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // No write-to-read bypass: same-cycle reads see the pre-edge value.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
    end

endmodule

// File: rtl/rv64_regfile_alu.sv
// Datapath slice for a single-cycle RV64I core: register file plus a
// 2-bit-opcode combinational ALU.
module rv64_regfile_alu
    import rv64_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_AW-1:0]   raddr1,
    output logic [XLEN-1:0]     rdata1,
    input  logic [REG_AW-1:0]   raddr2,
    output logic [XLEN-1:0]     rdata2,
    input  logic                we,
    input  logic [REG_AW-1:0]   waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    input  logic [1:0]          aluop,
    output logic [XLEN-1:0]     result
);

    rv64_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    // Stateless ALU; both add encodings are intentionally identical.
    always_comb begin
        result = '0;
        case (aluop_t'(aluop))
            ALU_ADD0: result = src1 + src2;
            ALU_ADD:  result = src1 + src2;
            ALU_SLTU: result = {(XLEN-1)'(0), (src1 < src2)};
            ALU_SUB:  result = src1 - src2;
            default:  result = '0;
        endcase
    end

endmodule

// File: tb/tb_rv64_regfile_alu.sv
// Directed self-checking bench for rv64_regfile_alu.
module tb_rv64_regfile_alu;

    logic        clk;
    logic        rst;
    logic [4:0]  raddr1;
    logic [63:0] rdata1;
    logic [4:0]  raddr2;
    logic [63:0] rdata2;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [1:0]  aluop;
    logic [63:0] result;

    int passed = 0;
    int total  = 0;

    rv64_regfile_alu dut (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .src1   (src1),
        .src2   (src2),
        .aluop  (aluop),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        we = 1'b1; waddr = 5'd5; wdata = 64'h1234;
        @(posedge clk); #1;
        raddr1 = 5'd5;
        #1;
        total++;
        if (rdata1 !== 64'h1234) $display("FAIL pre_reset_write: got %h expected %h", rdata1, 64'h1234);
        else passed++;
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 5'd6; wdata = 64'd7;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        raddr1 = 5'd5; raddr2 = 5'd6;
        #1;
        total++;
        if (rdata1 !== 64'h0) $display("FAIL reset_reg5: got %h expected %h", rdata1, 64'h0);
        else passed++;
        total++;
        if (rdata2 !== 64'h0) $display("FAIL reset_prio_reg6: got %h expected %h", rdata2, 64'h0);
        else passed++;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #1;
            total++;
            if (rdata1 !== 64'h0 || rdata2 !== 64'h0)
                $display("FAIL reset_all addr %0d: got %h/%h expected 0", a, rdata1, rdata2);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        we = 1'b1; waddr = 5'd10; wdata = 64'hDEAD_BEEF_0000_0001;
        raddr1 = 5'd10; raddr2 = 5'd10;
        #1;
        total++;
        if (rdata1 !== 64'h0 || rdata2 !== 64'h0)
            $display("FAIL rdw_old_value: got %h/%h expected 0", rdata1, rdata2);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (rdata1 !== 64'hDEAD_BEEF_0000_0001)
            $display("FAIL write_read_p1: got %h expected %h", rdata1, 64'hDEAD_BEEF_0000_0001);
        else passed++;
        total++;
        if (rdata2 !== 64'hDEAD_BEEF_0000_0001)
            $display("FAIL write_read_p2: got %h expected %h", rdata2, 64'hDEAD_BEEF_0000_0001);
        else passed++;
        // we=0 must leave reg10 untouched
        @(negedge clk);
        we = 1'b0; wdata = 64'h5555;
        @(posedge clk); #1;
        total++;
        if (rdata1 !== 64'hDEAD_BEEF_0000_0001)
            $display("FAIL we0_hold: got %h expected %h", rdata1, 64'hDEAD_BEEF_0000_0001);
        else passed++;
    endtask

    task automatic test_x0();
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF;
        raddr1 = 5'd0; raddr2 = 5'd0;
        @(posedge clk); #1;
        total++;
        if (rdata1 !== 64'h0 || rdata2 !== 64'h0)
            $display("FAIL x0_write: got %h/%h expected 0", rdata1, rdata2);
        else passed++;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_add();
        logic [63:0] a_v [3];
        logic [63:0] b_v [3];
        logic [63:0] e_v [3];
        a_v[0] = 64'hFFFF_FFFF_FFFF_FFFF; b_v[0] = 64'd1;                   e_v[0] = 64'd0;
        a_v[1] = 64'd100;                 b_v[1] = 64'hFFFF_FFFF_FFFF_FFFC; e_v[1] = 64'd96;
        a_v[2] = 64'h0000_0001_0000_0000; b_v[2] = 64'h0000_0000_FFFF_FFFF; e_v[2] = 64'h0000_0001_FFFF_FFFF;
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < 3; i++) begin
                aluop = 2'(op); src1 = a_v[i]; src2 = b_v[i];
                #1;
                total++;
                if (result !== e_v[i])
                    $display("FAIL add op%0d vec%0d: got %h expected %h", op, i, result, e_v[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_sltu();
        logic [63:0] a_v [4];
        logic [63:0] b_v [4];
        logic [63:0] e_v [4];
        a_v[0] = 64'd5; b_v[0] = 64'hFFFF_FFFF_FFFF_FFFF; e_v[0] = 64'd1;
        a_v[1] = 64'd5; b_v[1] = 64'd5;                   e_v[1] = 64'd0;
        a_v[2] = 64'd6; b_v[2] = 64'd5;                   e_v[2] = 64'd0;
        a_v[3] = 64'd0; b_v[3] = 64'hFFFF_FFFF_FFFF_FFFF; e_v[3] = 64'd1;
        aluop = 2'b10;
        for (int i = 0; i < 4; i++) begin
            src1 = a_v[i]; src2 = b_v[i];
            #1;
            total++;
            if (result !== e_v[i])
                $display("FAIL sltu vec%0d: got %h expected %h", i, result, e_v[i]);
            else passed++;
        end
    endtask

    task automatic test_sub_concurrency();
        @(negedge clk);
        aluop = 2'b11; src1 = 64'd0; src2 = 64'd1;
        we = 1'b1; waddr = 5'd31; wdata = 64'd3; raddr2 = 5'd31;
        #1;
        total++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL sub_wrap: got %h expected %h", result, 64'hFFFF_FFFF_FFFF_FFFF);
        else passed++;
        total++;
        if (rdata2 !== 64'h0) $display("FAIL r31_before_edge: got %h expected %h", rdata2, 64'h0);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL sub_after_edge: got %h expected %h", result, 64'hFFFF_FFFF_FFFF_FFFF);
        else passed++;
        total++;
        if (rdata2 !== 64'd3) $display("FAIL r31_after_edge: got %h expected %h", rdata2, 64'd3);
        else passed++;
        @(negedge clk);
        we = 1'b0;
        src1 = 64'd10; src2 = 64'd3;
        #1;
        total++;
        if (result !== 64'd7) $display("FAIL sub_basic: got %h expected %h", result, 64'd7);
        else passed++;
        // ALU is stateless: reset must not disturb result
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (result !== 64'd7) $display("FAIL result_under_reset: got %h expected %h", result, 64'd7);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; src1 = '0; src2 = '0; aluop = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_x0();
        test_add();
        test_sltu();
        test_sub_concurrency();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
